// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hamming_pkg
// Description : Hamming code helpers (parity width, bit positions, encoder)
//               shared by the streaming encoder and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int c_MAX_DATA_W = 64;
    localparam int c_MAX_PAR_W  = 7;

    // Smallest r with 2**r >= data_w + r + 1.
    function automatic int par_width(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Data index i maps to the i-th non-power-of-two position (3,5,6,7,9,...).
    function automatic int hamming_pos(input int i);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 3; p <= c_MAX_DATA_W + c_MAX_PAR_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == i && res == 0) begin
                    res = p;
                end
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

    // Parity field: bit (par_w-1-j) holds p_j. Bits above par_w stay zero.
    function automatic logic [c_MAX_PAR_W-1:0] encode(
        input logic [c_MAX_DATA_W-1:0] data,
        input int                      data_w
    );
        logic [c_MAX_PAR_W-1:0] field;
        int                     pw;
        int                     pos;
        field = '0;
        pw    = par_width(data_w);
        for (int j = 0; j < c_MAX_PAR_W; j++) begin
            for (int i = 0; i < c_MAX_DATA_W; i++) begin
                pos = hamming_pos(i);
                if (j < pw && i < data_w && pos[j]) begin
                    field[pw-1-j] = field[pw-1-j] ^ data[i];
                end
            end
        end
        return field;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buffer
// Description : Two-slot valid/ready register slice (main + skid) with a
//               registered in_ready, giving full throughput under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] r_main;
    logic         r_main_valid;
    logic [W-1:0] r_skid;
    logic         r_skid_full;
    logic         w_in_fire;
    logic         w_out_fire;

    assign in_ready   = !r_skid_full;
    assign out_valid  = r_main_valid;
    assign out_data   = r_main;
    assign w_in_fire  = in_valid && !r_skid_full;
    assign w_out_fire = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_full  <= 1'b0;
        end else if (!r_main_valid || w_out_fire) begin
            // Main slot is free this edge; the skid word always has priority
            // (in_ready is low whenever the skid is occupied).
            if (r_skid_full) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_full  <= 1'b0;
            end else if (w_in_fire) begin
                r_main       <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid      <= in_data;
            r_skid_full <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hamming_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_stream_encoder
// Description : Streaming parametrised Hamming encoder with skid buffering and
//               a delivered-word counter. Define HAMMING_SECDED_EN to append an
//               overall even-parity bit (SEC-DED) as the codeword MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_width(DATA_W),
`ifdef HAMMING_SECDED_EN
    localparam int CW_W   = DATA_W + PAR_W + 1
`else
    localparam int CW_W   = DATA_W + PAR_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_codeword,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [c_MAX_DATA_W-1:0]   w_data_ext;
    logic [c_MAX_PAR_W-1:0]    w_field;
    logic                      w_unused_field;
    logic [DATA_W+PAR_W-1:0]   w_cw0;
    logic [CW_W-1:0]           w_cw;
    logic [CNT_W-1:0]          r_word_cnt;

    always_comb begin
        w_data_ext             = '0;
        w_data_ext[DATA_W-1:0] = in_data;
    end

    assign w_field        = encode(w_data_ext, DATA_W);
    assign w_unused_field = ^w_field;
    assign w_cw0          = {in_data, w_field[PAR_W-1:0]};

`ifdef HAMMING_SECDED_EN
    assign w_cw = {^w_cw0, w_cw0};
`else
    assign w_cw = w_cw0;
`endif

    stream_skid_buffer #(
        .W (CW_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_codeword)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    assign word_cnt = r_word_cnt;

endmodule
`default_nettype wire
